ycbcr_to_rgb: RTL

Pipelined YCbCr-to-RGB888 converter (BT.601 full-range, JPEG coefficients) for the display/preview path. It is the inverse of the capture-side RGB-to-YCbCr stage. It accepts one 8-bit Y/Cb/Cr pixel per clock together with video timing (de/hsync/vsync). It emits clamped RGB888 with the timing signals delayed by exactly the datapath latency, so the output stream is a drop-in video source for the downstream VGA/LCD or DDR writer.

---
 rtl/ycbcr_pkg.sv | 28 ++
 rtl/sync_shift.sv | 23 ++
 rtl/ycbcr_to_rgb.sv | 94 +++++++++
 3 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants and clamp helper for the YCbCr -> RGB888 conversion path.
// Coefficients are BT.601 full-range (JPEG) scaled by 256.
package ycbcr_pkg;
  localparam int PIX_W    = 8;
  localparam int CB_W     = 9;
  localparam int YS_W     = 17;
  localparam int PRD_W    = 18;
  localparam int SUM_W    = 19;
  localparam int TMG_W    = 3;
  localparam int OUT_W    = TMG_W + 3*PIX_W;
  localparam int CONV_LAT = 4;

  localparam int KR_CR  = 359;
  localparam int KG_CB  = 88;
  localparam int KG_CR  = 183;
  localparam int KB_CB  = 454;
  localparam int OFFSET = 128;
  localparam int RND    = 128;

  // Drop the 8 fraction bits, then saturate to [0,255].
  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] s;
    s = v >>> 8;
    if (s[SUM_W-1])               return '0;
    else if (|s[SUM_W-2:PIX_W])   return '1;
    else                          return s[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/sync_shift.sv
// Async-reset delay line: DEPTH register stages of WIDTH bits (DEPTH >= 1).
module sync_shift #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/ycbcr_to_rgb.sv
// 4-stage YCbCr -> RGB888 converter with timing signals delayed to match,
// plus optional EXTRA_DLY alignment stages on all 27 output bits.
module ycbcr_to_rgb
  import ycbcr_pkg::*;
#(
  parameter int EXTRA_DLY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_de,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic [PIX_W-1:0] in_Y,
  input  logic [PIX_W-1:0] in_Cb,
  input  logic [PIX_W-1:0] in_Cr,
  output logic             out_de,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic [PIX_W-1:0] out_R,
  output logic [PIX_W-1:0] out_G,
  output logic [PIX_W-1:0] out_B
);
  localparam logic signed [CB_W-1:0]  OFFS  = CB_W'(OFFSET);
  localparam logic signed [PRD_W-1:0] K_RCR = PRD_W'(KR_CR);
  localparam logic signed [PRD_W-1:0] K_GCB = PRD_W'(KG_CB);
  localparam logic signed [PRD_W-1:0] K_GCR = PRD_W'(KG_CR);
  localparam logic signed [PRD_W-1:0] K_BCB = PRD_W'(KB_CB);
  localparam logic signed [SUM_W-1:0] RND_S = SUM_W'(RND);

  logic signed [CB_W-1:0]  cb_s1, cr_s1;
  logic signed [YS_W-1:0]  ys_s1, ys_s2;
  logic signed [PRD_W-1:0] p_rcr, p_gcb, p_gcr, p_bcb;
  logic signed [SUM_W-1:0] r_s3, g_s3, b_s3;
  logic [PIX_W-1:0]        r_q, g_q, b_q;
  logic [TMG_W-1:0]        tmg_q;
  // de aligned with each datapath stage, used only for blanking at the clamp
  logic [CONV_LAT-1:1]     vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb_s1 <= '0; cr_s1 <= '0; ys_s1 <= '0; ys_s2 <= '0;
      p_rcr <= '0; p_gcb <= '0; p_gcr <= '0; p_bcb <= '0;
      r_s3  <= '0; g_s3  <= '0; b_s3  <= '0;
      r_q   <= '0; g_q   <= '0; b_q   <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[CONV_LAT-2:1], in_de};
      // S1: centre chroma, scale luma
      cb_s1 <= $signed({1'b0, in_Cb}) - OFFS;
      cr_s1 <= $signed({1'b0, in_Cr}) - OFFS;
      ys_s1 <= {1'b0, in_Y, 8'b0};
      // S2: products
      p_rcr <= K_RCR * PRD_W'(cr_s1);
      p_gcb <= K_GCB * PRD_W'(cb_s1);
      p_gcr <= K_GCR * PRD_W'(cr_s1);
      p_bcb <= K_BCB * PRD_W'(cb_s1);
      ys_s2 <= ys_s1;
      // S3: sums with rounding
      r_s3 <= SUM_W'(ys_s2) + SUM_W'(p_rcr) + RND_S;
      g_s3 <= SUM_W'(ys_s2) - SUM_W'(p_gcb) - SUM_W'(p_gcr) + RND_S;
      b_s3 <= SUM_W'(ys_s2) + SUM_W'(p_bcb) + RND_S;
      // S4: clamp, forced black outside active video
      if (vld_pipe[CONV_LAT-1]) begin
        r_q <= clamp_pix(r_s3);
        g_q <= clamp_pix(g_s3);
        b_q <= clamp_pix(b_s3);
      end else begin
        r_q <= '0; g_q <= '0; b_q <= '0;
      end
    end
  end

  sync_shift #(.DEPTH(CONV_LAT), .WIDTH(TMG_W)) u_tmg_shift (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({in_de, in_hsync, in_vsync}),
    .dout (tmg_q)
  );

  generate
    if (EXTRA_DLY > 0) begin : g_extra
      logic [OUT_W-1:0] dly_q;
      sync_shift #(.DEPTH(EXTRA_DLY), .WIDTH(OUT_W)) u_out_shift (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({tmg_q, r_q, g_q, b_q}),
        .dout (dly_q)
      );
      assign {out_de, out_hsync, out_vsync, out_R, out_G, out_B} = dly_q;
    end else begin : g_direct
      assign {out_de, out_hsync, out_vsync, out_R, out_G, out_B} = {tmg_q, r_q, g_q, b_q};
    end
  endgenerate
endmodule
